ssd_scan_driver: RTL

- Consumer end of the score path: takes BCD digit pairs (score tens/ones, plus two auxiliary digits such as timer tens/ones) and drives a 4-digit common-anode multiplexed seven-segment display.
- Time-multiplexes the digits with a refresh divider and decodes BCD to segments.
- Shadow-latches inputs once per frame so that a digit changing mid-scan cannot tear the display.
- Supports leading-zero blanking, per-digit decimal points and a whole-display blink for the game-over or high-score screens.

---
 rtl/ssd_scan_driver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Drives a 4-digit common-anode multiplexed seven-segment display from BCD
// digits. The digits are latched into a shadow copy once per frame so a value
// changing mid-scan cannot tear the display. Supports leading-zero blanking,
// per-digit decimal points and a whole-display blink.
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_mask,
    input  logic       lz_blank,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Scan / blink state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;
    logic             load_pending_q, load_pending_d;

    // Shadow copy of the inputs, packed {d3,d2,d1,d0}
    logic [15:0]      sh_dig_q, sh_dig_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic             sh_lz_q, sh_lz_d;

    // Registered outputs
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start_q, frame_start_d;

    // Intermediate decode terms
    logic             tick;
    logic             frame_edge;
    logic [3:0]       cur_dig;
    logic             z3, z2, z1;
    logic             blank;

    // Next-state computation for counters, shadow latch and display outputs
    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        frame_edge = tick && (idx_q == 2'd3);

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        // Shadow reloads on the first cycle out of reset and at each frame boundary.
        load_pending_d = 1'b0;
        sh_dig_d       = sh_dig_q;
        sh_dp_d        = sh_dp_q;
        sh_lz_d        = sh_lz_q;
        if (load_pending_q || frame_edge) begin
            sh_dig_d = {d3, d2, d1, d0};
            sh_dp_d  = dp_mask;
            sh_lz_d  = lz_blank;
        end
        frame_start_d = frame_edge;

        // Blink counter runs on refresh ticks only while blinking is enabled.
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        if (!blink_en) begin
            blk_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (tick) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        // Leading-zero suppression: a digit blanks only if it and every digit
        // to its left are zero. Digit 0 always shows.
        z3 = (sh_dig_q[15:12] == 4'd0);
        z2 = z3 && (sh_dig_q[11:8] == 4'd0);
        z1 = z2 && (sh_dig_q[7:4] == 4'd0);
        case (idx_q)
            2'd1:    blank = sh_lz_q && z1;
            2'd2:    blank = sh_lz_q && z2;
            2'd3:    blank = sh_lz_q && z3;
            default: blank = 1'b0;
        endcase

        cur_dig = sh_dig_q[{idx_q, 2'b00} +: 4];

        an_d  = ~(4'b0001 << idx_q);
        seg_d = bcd_to_seg(cur_dig);
        dp_d  = ~sh_dp_q[idx_q];
        if (blank) begin
            an_d  = 4'b1111;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
        // Blink-off only darkens the anodes; segments keep decoding.
        if (blink_en && phase_q) begin
            an_d = 4'b1111;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q          <= '0;
            idx_q          <= 2'd0;
            blk_cnt_q      <= '0;
            phase_q        <= 1'b0;
            load_pending_q <= 1'b1;
            sh_dig_q       <= 16'h0000;
            sh_dp_q        <= 4'h0;
            sh_lz_q        <= 1'b0;
            an_q           <= 4'b1111;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            blk_cnt_q      <= blk_cnt_d;
            phase_q        <= phase_d;
            load_pending_q <= load_pending_d;
            sh_dig_q       <= sh_dig_d;
            sh_dp_q        <= sh_dp_d;
            sh_lz_q        <= sh_lz_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule
